// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer (CTRL/PRESET/COUNT) with one-shot or auto-reload modes.
// Define TC_PRESCALE_EN to enable the CTRL[11:4] prescaler.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

`ifdef TC_PRESCALE_EN
    localparam int CW = 12;
`else
    localparam int CW = 4;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } stateT;

    stateT         state_q, state_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [31:0]   preset_q, preset_d;
    logic [31:0]   count_q, count_d;
    logic          intFlag_q, intFlag_d;

    logic [1:0]    regSel;
    logic          hit;
    logic          ctrlWe;
    logic          presetWe;
    logic          tick;
    logic          unusedBits;

    assign regSel   = addr[3:2];
    assign hit      = (addr[31:4] == BASE_ADDR[31:4]) && (regSel != 2'b11);
    assign ctrlWe   = we && hit && (regSel == 2'b00);
    assign presetWe = we && hit && (regSel == 2'b01);
    assign irq      = ctrl_q[3] & intFlag_q;

    assign unusedBits = ^{addr[1:0], wdata[31:CW]};

`ifdef TC_PRESCALE_EN
    logic [7:0] psc_q, psc_d;

    // COUNT only advances on cycles where the prescale counter has reached P
    assign tick = (psc_q == ctrl_q[11:4]);

    always_comb begin
        psc_d = psc_q;
        if (state_q == LOAD) begin
            psc_d = 8'd0;
        end else if ((state_q == CNT) && ctrl_q[0]) begin
            psc_d = tick ? 8'd0 : psc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= 8'd0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (regSel)
                2'b00:   rdata = {{(32-CW){1'b0}}, ctrl_q};
                2'b01:   rdata = preset_q;
                2'b10:   rdata = count_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        intFlag_d = intFlag_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = ctrl_q[0] ? CNT : IDLE;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d   = 32'd0;
                        intFlag_d = 1'b1;
                        state_d   = INT;
                    end
                end
            end
            INT: begin
                // Only MODE 01 reloads; the reserved modes 10/11 act as one-shot
                if (ctrl_q[2:1] == 2'b01) begin
                    intFlag_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A CPU write to CTRL overrides whatever the FSM did to EN/int_flag this cycle
        if (ctrlWe) begin
            ctrl_d    = wdata[CW-1:0];
            intFlag_d = 1'b0;
        end
        if (presetWe) begin
            preset_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            intFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            intFlag_q <= intFlag_d;
        end
    end

endmodule
